// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared defaults and helpers for the instruction fetch unit.
//   DefPcw/DefIw/DefFw/DefOuts/DefDepth/DefCw/DefResetPc : parameter defaults
//   fetchStride() : bytes covered by one fetch line
//   entryWidth()  : width of a receive-buffer entry {line, PC}
//   EntryW        : entry width for the default configuration
// ---------------------------------------------------------------------------
package ifetch_pkg;

    localparam int unsigned DefPcw     = 32;
    localparam int unsigned DefIw      = 32;
    localparam int unsigned DefFw      = 4;
    localparam int unsigned DefOuts    = 4;
    localparam int unsigned DefDepth   = 8;
    localparam int unsigned DefCw      = 8;
    localparam int unsigned DefResetPc = 0;

    // Byte distance between consecutive fetch addresses.
    function automatic int unsigned fetchStride(input int unsigned fw, input int unsigned iw);
        return (fw * iw) / 8;
    endfunction

    // Buffer entry is the fetched line with its PC in the low bits.
    function automatic int unsigned entryWidth(input int unsigned fw, input int unsigned iw,
                                               input int unsigned pcw);
        return fw * iw + pcw;
    endfunction

    localparam int unsigned EntryW = DefFw * DefIw + DefPcw;

endpackage

// File: rtl/ifetch_fifo.sv
// ---------------------------------------------------------------------------
// ifetch_fifo
// First-word-fall-through FIFO with synchronous clear; used both as the
// receive buffer and as the in-order tag queue of the fetch unit.
// Ports:
//   iClk, iReset      clock, synchronous active-high reset
//   iClear            synchronous flush; beats a same-cycle write and read
//   iWrite, iWData    push (accepted when not full, or full with a pop)
//   iRead             pop (ignored when empty)
//   oRData            head entry, zero when empty
//   oEmpty            no entries
//   oCount            number of entries
// ---------------------------------------------------------------------------
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic                         iClear,
    input  logic                         iWrite,
    input  logic [W-1:0]                 iWData,
    input  logic                         iRead,
    output logic [W-1:0]                 oRData,
    output logic                         oEmpty,
    output logic [$clog2(DEPTH+1)-1:0]   oCount
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wrPtrQ;
    logic [AW-1:0]   rdPtrQ;
    logic [CntW-1:0] cntQ;
    logic            full;
    logic            doRead;
    logic            doWrite;

    // Explicit wrap so non-power-of-two depths work too.
    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign oEmpty  = (cntQ == '0);
    assign full    = (cntQ == CntW'(DEPTH));
    assign doRead  = iRead & ~oEmpty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign doWrite = iWrite & (~full | doRead);

    always_ff @(posedge iClk) begin
        if (iReset || iClear) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            cntQ   <= '0;
        end else begin
            if (doWrite) begin
                wrPtrQ <= nextPtr(wrPtrQ);
            end
            if (doRead) begin
                rdPtrQ <= nextPtr(rdPtrQ);
            end
            case ({doWrite, doRead})
                2'b10:   cntQ <= cntQ + CntW'(1);
                2'b01:   cntQ <= cntQ - CntW'(1);
                default: cntQ <= cntQ;
            endcase
        end
    end

    // Storage needs no reset: a stale slot is never visible behind oEmpty.
    always_ff @(posedge iClk) begin
        if (doWrite) begin
            mem[wrPtrQ] <= iWData;
        end
    end

    assign oRData = oEmpty ? '0 : mem[rdPtrQ];
    assign oCount = cntQ;

endmodule

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch front end: issues sequential line fetches to the cache,
// tracks outstanding requests in order, buffers returned lines for the
// decoder and handles redirects by discarding in-flight responses.
// Ports:
//   iClk, iReset                  clock, synchronous active-high reset
//   iJumpVld, iJumpPC             redirect strobe and target
//   toCache_req, toCache_pc       fetch request and address
//   fromCache_ack                 request accepted this cycle
//   fromCache_resp/_instr         in-order response and fetched line
//   fromDec_RE                    decoder pop
//   toDec_RD, toDec_PC            head line and its PC
//   toDec_empty                   receive buffer empty
//   oTimeoutFatal                 sticky response timeout
// ---------------------------------------------------------------------------
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned    PCW      = DefPcw,
    parameter int unsigned    IW       = DefIw,
    parameter int unsigned    FW       = DefFw,
    parameter int unsigned    OUTS     = DefOuts,
    parameter int unsigned    DEPTH    = DefDepth,
    parameter int unsigned    CW       = DefCw,
    parameter logic [PCW-1:0] RESET_PC = PCW'(DefResetPc)
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iJumpVld,
    input  logic [PCW-1:0]      iJumpPC,
    output logic                toCache_req,
    output logic [PCW-1:0]      toCache_pc,
    input  logic                fromCache_ack,
    input  logic                fromCache_resp,
    input  logic [FW*IW-1:0]    fromCache_instr,
    input  logic                fromDec_RE,
    output logic [FW*IW-1:0]    toDec_RD,
    output logic [PCW-1:0]      toDec_PC,
    output logic                toDec_empty,
    output logic                oTimeoutFatal
);

    localparam int unsigned   StrideB = fetchStride(FW, IW);
    localparam int unsigned   LineW   = FW * IW;
    localparam int unsigned   EntW    = entryWidth(FW, IW, PCW);
    localparam int unsigned   InfW    = $clog2(OUTS + 1);
    localparam int unsigned   BufCntW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] ToMax   = '1;

    logic [PCW-1:0]     pcQ, pcD;
    logic [InfW-1:0]    dropCntQ, dropCntD;
    logic [CW-1:0]      toCntQ, toCntD;
    logic               fatalQ, fatalD;
    logic               jumpPrevQ;

    logic [InfW-1:0]    inflight;
    logic [InfW-1:0]    inflightD;
    logic               reqRaw;
    logic               accept;
    logic               respVld;
    logic               respDrop;
    logic               respKeep;

    logic [EntW-1:0]    bufHead;
    logic               bufEmpty;
    logic [BufCntW-1:0] bufCount;
    logic [PCW-1:0]     tagHead;
    logic               tagEmpty;
    logic [InfW-1:0]    tagCount;

    // The tag queue holds only responses that will be kept; dropCnt holds
    // the ones to be discarded, so together they are the inflight count.
    assign inflight = tagCount + dropCntQ;

    // Credit check: every inflight request may still need a buffer slot.
    assign reqRaw = (inflight < InfW'(OUTS))
                 && ((32'(inflight) + 32'(bufCount)) < DEPTH)
                 && !fatalQ
                 && !jumpPrevQ;

    assign toCache_req = reqRaw & ~iReset;
    assign accept      = toCache_req & fromCache_ack;
    assign respVld     = fromCache_resp & (inflight != '0);
    assign respDrop    = respVld & (dropCntQ != '0);
    // A kept response needs a tag; a redirect in the same cycle discards it.
    assign respKeep    = fromCache_resp & ~iJumpVld & (dropCntQ == '0) & ~tagEmpty;

    always_comb begin
        inflightD = inflight;
        if (accept) begin
            inflightD = inflightD + InfW'(1);
        end
        if (respVld) begin
            inflightD = inflightD - InfW'(1);
        end

        dropCntD = dropCntQ;
        if (iJumpVld) begin
            dropCntD = inflightD;
        end else if (respDrop) begin
            dropCntD = dropCntQ - InfW'(1);
        end

        pcD = pcQ;
        if (iJumpVld) begin
            pcD = iJumpPC;
        end else if (accept) begin
            pcD = pcQ + PCW'(StrideB);
        end

        toCntD = toCntQ;
        if ((inflight == '0) || fromCache_resp) begin
            toCntD = '0;
        end else if (toCntQ != ToMax) begin
            toCntD = toCntQ + CW'(1);
        end

        fatalD = fatalQ | (toCntD == ToMax);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            pcQ       <= RESET_PC;
            dropCntQ  <= '0;
            toCntQ    <= '0;
            fatalQ    <= 1'b0;
            jumpPrevQ <= 1'b0;
        end else begin
            pcQ       <= pcD;
            dropCntQ  <= dropCntD;
            toCntQ    <= toCntD;
            fatalQ    <= fatalD;
            jumpPrevQ <= iJumpVld;
        end
    end

    ifetch_fifo #(
        .W     (PCW),
        .DEPTH (OUTS)
    ) uTagQ (
        .iClk   (iClk),
        .iReset (iReset),
        .iClear (iJumpVld),
        .iWrite (accept),
        .iWData (pcQ),
        .iRead  (respKeep),
        .oRData (tagHead),
        .oEmpty (tagEmpty),
        .oCount (tagCount)
    );

    ifetch_fifo #(
        .W     (EntW),
        .DEPTH (DEPTH)
    ) uBuf (
        .iClk   (iClk),
        .iReset (iReset),
        .iClear (iJumpVld),
        .iWrite (respKeep),
        .iWData ({fromCache_instr, tagHead}),
        .iRead  (fromDec_RE),
        .oRData (bufHead),
        .oEmpty (bufEmpty),
        .oCount (bufCount)
    );

    // Outputs show reset values for the whole time iReset is high.
    always_comb begin
        toCache_pc    = pcQ;
        toDec_RD      = bufHead[EntW-1 -: LineW];
        toDec_PC      = bufHead[PCW-1:0];
        toDec_empty   = bufEmpty;
        oTimeoutFatal = fatalQ;
        if (iReset) begin
            toCache_pc    = RESET_PC;
            toDec_RD      = '0;
            toDec_PC      = '0;
            toDec_empty   = 1'b1;
            oTimeoutFatal = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    localparam int unsigned PCW    = 32;
    localparam int unsigned IW     = 32;
    localparam int unsigned FW     = 4;
    localparam int unsigned OUTS   = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CW     = 4;
    localparam int unsigned STRIDE = 16;
    localparam int          TO_MAX = 15;

    logic           iClk = 1'b0;
    logic           iReset = 1'b1;
    logic           iJumpVld = 1'b0;
    logic [31:0]    iJumpPC = '0;
    logic           toCache_req;
    logic [31:0]    toCache_pc;
    logic           fromCache_ack = 1'b0;
    logic           fromCache_resp = 1'b0;
    logic [127:0]   fromCache_instr = '0;
    logic           fromDec_RE = 1'b0;
    logic [127:0]   toDec_RD;
    logic [31:0]    toDec_PC;
    logic           toDec_empty;
    logic           oTimeoutFatal;

    int nCmp = 0;
    int nBad = 0;

    ifetch_unit #(
        .PCW      (PCW),
        .IW       (IW),
        .FW       (FW),
        .OUTS     (OUTS),
        .DEPTH    (DEPTH),
        .CW       (CW),
        .RESET_PC (32'h0)
    ) dut (
        .iClk            (iClk),
        .iReset          (iReset),
        .iJumpVld        (iJumpVld),
        .iJumpPC         (iJumpPC),
        .toCache_req     (toCache_req),
        .toCache_pc      (toCache_pc),
        .fromCache_ack   (fromCache_ack),
        .fromCache_resp  (fromCache_resp),
        .fromCache_instr (fromCache_instr),
        .fromDec_RE      (fromDec_RE),
        .toDec_RD        (toDec_RD),
        .toDec_PC        (toDec_PC),
        .toDec_empty     (toDec_empty),
        .oTimeoutFatal   (oTimeoutFatal)
    );

    always #5 iClk = ~iClk;

    // Reference model: outstanding requests in order with a discard flag,
    // plus the decoder-visible line queue.
    typedef struct {
        logic [31:0] pc;
        bit          dropped;
    } outst_t;
    typedef struct {
        logic [127:0] line;
        logic [31:0]  pc;
    } ent_t;

    outst_t      outQ[$];
    ent_t        bufQ[$];
    logic [31:0] mPc = '0;
    int          mTo = 0;
    bit          mFatal = 1'b0;
    bit          mJumpPrev = 1'b0;

    function automatic bit mReq();
        return !iReset && (outQ.size() < OUTS) && (outQ.size() + bufQ.size() < DEPTH)
               && !mFatal && !mJumpPrev;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare on the falling edge, then advance the model by the coming
    // rising edge (inputs are stable from just after one rising edge to the next).
    initial begin : compare
        bit           acc;
        bit           jmp;
        bit           eEmpty;
        outst_t       o;
        forever begin
            @(negedge iClk);
            eEmpty = iReset || (bufQ.size() == 0);
            chk("req", toCache_req, mReq());
            chk("cachePc", toCache_pc, iReset ? 32'h0 : mPc);
            chk("empty", toDec_empty, eEmpty);
            chk("decRd", toDec_RD, eEmpty ? 128'h0 : bufQ[0].line);
            chk("decPc", toDec_PC, eEmpty ? 32'h0 : bufQ[0].pc);
            chk("fatal", oTimeoutFatal, !iReset && mFatal);

            if (iReset) begin
                outQ.delete();
                bufQ.delete();
                mPc       = '0;
                mTo       = 0;
                mFatal    = 1'b0;
                mJumpPrev = 1'b0;
            end else begin
                acc = mReq() && fromCache_ack;
                jmp = iJumpVld;
                if (outQ.size() == 0 || fromCache_resp) begin
                    mTo = 0;
                end else if (mTo < TO_MAX) begin
                    mTo++;
                end
                if (mTo == TO_MAX) begin
                    mFatal = 1'b1;
                end
                if (fromDec_RE && bufQ.size() > 0) begin
                    void'(bufQ.pop_front());
                end
                if (fromCache_resp && outQ.size() > 0) begin
                    o = outQ.pop_front();
                    if (!o.dropped && !jmp) begin
                        bufQ.push_back(ent_t'{fromCache_instr, o.pc});
                    end
                end
                if (acc) begin
                    outQ.push_back(outst_t'{mPc, jmp});
                    mPc = mPc + STRIDE;
                end
                if (jmp) begin
                    foreach (outQ[i]) outQ[i].dropped = 1'b1;
                    bufQ.delete();
                    mPc = iJumpPC;
                end
                mJumpPrev = jmp;
            end
        end
    end

    // One clock cycle of stimulus; returns just after the falling edge.
    task automatic cyc(input bit rst, input bit jmp, input logic [31:0] jpc,
                       input bit ack, input bit resp, input bit rd);
        @(posedge iClk);
        #1;
        iReset          = rst;
        iJumpVld        = jmp;
        iJumpPC         = jpc;
        fromCache_ack   = ack;
        fromCache_resp  = resp;
        fromDec_RE      = rd;
        fromCache_instr = {$urandom, $urandom, $urandom, $urandom};
        @(negedge iClk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : stim
        logic [127:0] line0;
        logic [31:0]  jpc;

        // Reset values
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("lit_rst_req", toCache_req, 1'b0);
        chk("lit_rst_empty", toDec_empty, 1'b1);
        chk("lit_rst_decpc", toDec_PC, 32'h0);
        chk("lit_rst_fatal", oTimeoutFatal, 1'b0);

        // Sequential fetch addresses, request straight after reset
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("lit_seq_req", toCache_req, 1'b1);
            chk("lit_seq_pc", toCache_pc, 32'(k * 16));
        end
        idle();
        chk("lit_hold_pc", toCache_pc, 32'h30);

        // Redirect with 3 inflight: all three responses discarded
        cyc(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_jmp_noreq", toCache_req, 1'b0);
        chk("lit_jmp_pc", toCache_pc, 32'h1000);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            chk("lit_drop_empty", toDec_empty, 1'b1);
        end
        idle();
        chk("lit_drop_empty2", toDec_empty, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        line0 = fromCache_instr;
        chk("lit_fwft_empty", toDec_empty, 1'b1);
        idle();
        chk("lit_jmp_decpc", toDec_PC, 32'h1000);
        chk("lit_jmp_decrd", toDec_RD, line0);

        // Redirect together with ack and resp
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h2000, 1'b1, 1'b1, 1'b0);
        idle();
        chk("lit_same_empty", toDec_empty, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("lit_same_empty2", toDec_empty, 1'b1);
        chk("lit_same_pc", toCache_pc, 32'h2000);

        // Decoder never pops: exactly DEPTH lines buffered
        repeat (2) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (30) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("lit_full_req", toCache_req, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            chk("lit_full_decpc", toDec_PC, 32'(i * 16));
        end
        idle();
        chk("lit_full_drained", toDec_empty, 1'b1);

        // PC wrap-around
        cyc(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
        idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("lit_wrap_pc0", toCache_pc, 32'hFFFF_FFF0);
        idle();
        chk("lit_wrap_pc1", toCache_pc, 32'h0);

        // Timeout with CW=4
        repeat (2) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        repeat (15) idle();
        chk("lit_to_notyet", oTimeoutFatal, 1'b0);
        idle();
        chk("lit_to_fatal", oTimeoutFatal, 1'b1);
        chk("lit_to_noreq", toCache_req, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        idle();
        chk("lit_to_sticky", oTimeoutFatal, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_to_clear", oTimeoutFatal, 1'b0);
        chk("lit_to_req", toCache_req, 1'b1);

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            jpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 : $urandom;
            cyc($urandom_range(0, 599) == 0,
                $urandom_range(0, 39) == 0,
                jpc,
                $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 60,
                $urandom_range(0, 99) < 50);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
